clog2_vector_checker: RTL and testbench
=======================================

// Module: clog2_vector_checker
// PURPOSE
//   Clocked stimulus generator and result scoreboard for the clog2 system test.
//   Drives pseudo-random {a,n1,n2} vectors to the spec and impl DUT instances,
//   waits a fixed settle time, then compares all DUT outputs with 4-state case
//   equality. Keeps pass/fail counts and captures the first failing vector.
//   Sits upstream (stimulus) and downstream (comparison) of the DUT pair.
// PARAMETERS
//   NUM_OUTS    11       number of DUT output vectors compared
//   OUT_W       41       width of each DUT output vector
//   STIM_W      12       stimulus width, {a[3:0],n1[3:0],n2[3:0]}; must be <=16
//   NUM_VECS    1000     vectors per run; 0 is legal
//   SETTLE_CYC  2        cycles between stimulus update and compare; must be >=1
//   SEED        16'hACE1 LFSR seed; 0 is replaced by 16'h0001
// PORTS
//   clk              in   1                  single clock, rising edge
//   rst              in   1                  synchronous reset, active-high
//   start            in   1                  pulse; starts a run from IDLE or DONE
//   stim             out  STIM_W             stimulus to both DUTs
//   spec_flat        in   NUM_OUTS*OUT_W     spec outputs, o0 in the LSBs
//   impl_flat        in   NUM_OUTS*OUT_W     impl outputs, same packing
//   busy             out  1                  run in progress
//   done             out  1                  run finished; held until next start
//   vec_count        out  32                 vectors checked in this run
//   fail_count       out  32                 failing vectors; saturates at all-ones
//   first_fail_vld   out  1                  first_fail_* fields are valid
//   first_fail_stim  out  STIM_W             stimulus of the first failing vector
//   first_fail_mask  out  NUM_OUTS           bit k set = output ok mismatched
// BEHAVIOUR
//   Reset: state IDLE, LFSR=SEED, stim=0, busy=0, done=0, counts=0,
//     first_fail_vld=0, first_fail_stim=0, first_fail_mask=0. rst mid-run
//     aborts the run immediately; no partial results are retained.
//   FSM: IDLE -> (start) -> APPLY -> SETTLE -> CHECK -> APPLY | DONE.
//     On start: clear counts and the first_fail_* fields, reload LFSR=SEED.
//     If NUM_VECS==0, go straight to DONE.
//     APPLY (1 cycle): stim <= lfsr[STIM_W-1:0]; advance the LFSR one step.
//     SETTLE: hold for SETTLE_CYC cycles.
//     CHECK (1 cycle): mask[k] = (impl_k !== spec_k); vec_count+1; if
//       |mask, fail_count+1 (saturating); if first_fail_vld==0, capture stim
//       and mask and set first_fail_vld. If vec_count+1==NUM_VECS go to DONE,
//       else go to APPLY.
//     DONE: done=1, busy=0. stim holds its last value. start re-runs.
//   busy=1 in APPLY, SETTLE and CHECK. start is ignored while busy.
//   Per-vector latency: SETTLE_CYC+2 cycles. Total run: NUM_VECS*(SETTLE_CYC+2)
//     cycles from the first APPLY to done.
//   LFSR: 16-bit Fibonacci, taps 16,14,13,11 (maximal length). It never
//     reaches 0. Under a fixed SEED the sequence is deterministic across runs.
//   Comparison: in simulation, an X or Z on either side counts as a mismatch
//     unless both sides match bit-for-bit. Synthesis compares 2-state.
// STRUCTURE
//   Shared package vl_systest_pkg: state enum {IDLE,APPLY,SETTLE,CHECK,DONE},
//     LFSR tap constant, and the 32-bit counter width constant.
//   One sub-module, systest_lfsr16 (load, step, value). The FSM, counters and
//     compare logic stay in this module.
// TESTING
//   1 Reset, then start; impl_flat tied to spec_flat, NUM_VECS=1000 ->
//     done after 4000 cycles; vec_count=1000, fail_count=0, first_fail_vld=0.
//   2 Force impl o3 bit0 inverted when stim==the 5th LFSR value ->
//     fail_count=1, first_fail_stim=that value, first_fail_mask=11'h008.
//   3 Invert impl o0 and o10 on every vector -> fail_count=1000,
//     first_fail_mask=11'h401, first_fail_stim=the 1st LFSR value.
//   4 Drive X on spec o7 for one vector -> that vector counts as failing;
//     mask bit7=1.
//   5 Assert rst at vector 500 -> next cycle all outputs are at reset values;
//     a new start replays the identical stim sequence.
//   6 NUM_VECS=0 -> done one cycle after start; counts=0. A start pulse while
//     busy changes nothing.

Source files
------------

// File: rtl/vl_systest_pkg.sv
// Shared types and constants for the clog2 system-test stimulus/scoreboard block.
package vl_systest_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned CNT_W  = 32;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/systest_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with synchronous load of a non-zero seed.
module systest_lfsr16
    import vl_systest_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int unsigned       OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] value
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic              feedback_c;

    assign feedback_c = ^(lfsr_q & LFSR_TAPS);

    // Reset and load both restart the sequence from the seed; step shifts once.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr_q <= SEED_EFF;
        end else if (step) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], feedback_c};
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/clog2_vector_checker.sv
// Stimulus generator and scoreboard: drives LFSR vectors to a spec/impl DUT
// pair, waits a fixed settle time, then compares every output vector.
module clog2_vector_checker
    import vl_systest_pkg::*;
#(
    parameter int unsigned       NUM_OUTS   = 11,
    parameter int unsigned       OUT_W      = 41,
    parameter int unsigned       STIM_W     = 12,
    parameter int unsigned       NUM_VECS   = 1000,
    parameter int unsigned       SETTLE_CYC = 2,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [STIM_W-1:0]         stim,
    input  logic [NUM_OUTS*OUT_W-1:0] spec_flat,
    input  logic [NUM_OUTS*OUT_W-1:0] impl_flat,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          vec_count,
    output logic [CNT_W-1:0]          fail_count,
    output logic                      first_fail_vld,
    output logic [STIM_W-1:0]         first_fail_stim,
    output logic [NUM_OUTS-1:0]       first_fail_mask
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e                state;
    logic   [SET_W-1:0]    settle_cnt;
    logic   [STIM_W-1:0]   lfsr_val;
    logic                  lfsr_load_c;
    logic                  lfsr_step_c;
    logic   [NUM_OUTS-1:0] mask_c;
    logic   [CNT_W-1:0]    vec_next_c;

    assign lfsr_load_c = start && ((state == IDLE) || (state == DONE));
    assign lfsr_step_c = (state == APPLY);
    assign vec_next_c  = vec_count + CNT_W'(1);

    systest_lfsr16 #(
        .SEED  (SEED),
        .OUT_W (STIM_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load_c),
        .step  (lfsr_step_c),
        .value (lfsr_val)
    );

    // Per-output mismatch flags; case inequality so X/Z only match X/Z exactly.
    always_comb begin
        mask_c = '0;
        for (int k = 0; k < int'(NUM_OUTS); k++) begin
            mask_c[k] = (impl_flat[k*OUT_W +: OUT_W] !== spec_flat[k*OUT_W +: OUT_W]);
        end
    end

    // Run sequencer with counters and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            vec_count       <= '0;
            fail_count      <= '0;
            first_fail_vld  <= 1'b0;
            first_fail_stim <= '0;
            first_fail_mask <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_count       <= '0;
                        fail_count      <= '0;
                        first_fail_vld  <= 1'b0;
                        first_fail_stim <= '0;
                        first_fail_mask <= '0;
                        if (NUM_VECS == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= APPLY;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    stim       <= lfsr_val;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                CHECK: begin
                    vec_count <= vec_next_c;
                    if (|mask_c) begin
                        if (fail_count != '1) begin
                            fail_count <= fail_count + CNT_W'(1);
                        end
                        if (!first_fail_vld) begin
                            first_fail_vld  <= 1'b1;
                            first_fail_stim <= stim;
                            first_fail_mask <= mask_c;
                        end
                    end
                    if (vec_next_c == CNT_W'(NUM_VECS)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= APPLY;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clog2_vector_checker.sv
// Directed testbench for clog2_vector_checker with a reference LFSR sequence.
module tb_clog2_vector_checker;

    localparam int unsigned NUM_OUTS = 11;
    localparam int unsigned OUT_W    = 41;
    localparam int unsigned STIM_W   = 12;
    localparam int unsigned NV       = 1000;
    localparam int unsigned FW       = NUM_OUTS * OUT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start0;
    logic [STIM_W-1:0] stim, stim0;
    logic [FW-1:0]     spec_flat, impl_flat;
    logic              busy, done, busy0, done0;
    logic [31:0]       vec_count, fail_count, vec0, fail0;
    logic              ffv, ffv0;
    logic [STIM_W-1:0] ffs, ffs0;
    logic [NUM_OUTS-1:0] ffm, ffm0;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    logic [STIM_W-1:0] vexp [1:NV];

    always #5 clk = ~clk;

    clog2_vector_checker #(
        .NUM_OUTS(NUM_OUTS), .OUT_W(OUT_W), .STIM_W(STIM_W),
        .NUM_VECS(NV), .SETTLE_CYC(2), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim),
        .spec_flat(spec_flat), .impl_flat(impl_flat),
        .busy(busy), .done(done), .vec_count(vec_count), .fail_count(fail_count),
        .first_fail_vld(ffv), .first_fail_stim(ffs), .first_fail_mask(ffm)
    );

    clog2_vector_checker #(
        .NUM_OUTS(NUM_OUTS), .OUT_W(OUT_W), .STIM_W(STIM_W),
        .NUM_VECS(0), .SETTLE_CYC(2), .SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stim(stim0),
        .spec_flat(spec_flat), .impl_flat(impl_flat),
        .busy(busy0), .done(done0), .vec_count(vec0), .fail_count(fail0),
        .first_fail_vld(ffv0), .first_fail_stim(ffs0), .first_fail_mask(ffm0)
    );

    // Stand-in DUT pair: both produce a stim-derived pattern, faults injected per mode.
    always_comb begin
        for (int k = 0; k < int'(NUM_OUTS); k++) begin
            spec_flat[k*OUT_W +: OUT_W] = {stim, ~stim, stim, 5'(k)};
        end
        impl_flat = spec_flat;
        if (mode == 1 && vec_count == 32'd4) begin
            impl_flat[3*OUT_W] = ~impl_flat[3*OUT_W];
        end
        if (mode == 2) begin
            impl_flat[0 +: OUT_W]        = ~spec_flat[0 +: OUT_W];
            impl_flat[10*OUT_W +: OUT_W] = ~spec_flat[10*OUT_W +: OUT_W];
        end
        if (mode == 3 && vec_count == 32'd2) begin
            spec_flat[7*OUT_W +: OUT_W] = 'x;
        end
    end

    // Reference sequence: x^16+x^14+x^13+x^11, new bit shifted in at the LSB.
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic build_ref();
        logic [15:0] s;
        s = 16'hACE1;
        for (int j = 1; j <= int'(NV); j++) begin
            vexp[j] = s[11:0];
            s = ref_step(s);
        end
    endtask

    // Pulse start so it is sampled on one edge; returns 1 time unit after that edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, counting edges after the start edge; -1 if it never comes.
    task automatic wait_done(input int from, output int at);
        at = -1;
        for (int c = from + 1; c <= 6000; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                at = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stim !== 12'h000) begin errors++; $display("FAIL reset_stim got=%h exp=000", stim); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
        checks++; if (vec_count !== 32'd0 || fail_count !== 32'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", vec_count, fail_count); end
        checks++; if ({ffv, ffs, ffm} !== '0) begin errors++; $display("FAIL reset_first_fail got=%b/%h/%h exp=0", ffv, ffs, ffm); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_run();
        int at;
        mode = 0;
        do_start();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL clean_busy got=%b%b exp=10", busy, done); end
        @(posedge clk); #1;
        for (int j = 1; j <= 4; j++) begin
            checks++; if (stim !== vexp[j]) begin errors++; $display("FAIL clean_stim%0d got=%h exp=%h", j, stim, vexp[j]); end
            if (j < 4) begin repeat (4) @(posedge clk); #1; end
        end
        wait_done(13, at);
        checks++; if (at != 4000) begin errors++; $display("FAIL clean_latency got=%0d exp=4000", at); end
        checks++; if (vec_count !== 32'd1000 || fail_count !== 32'd0) begin errors++; $display("FAIL clean_counts got=%0d/%0d exp=1000/0", vec_count, fail_count); end
        checks++; if (ffv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clean_ffv_busy got=%b/%b exp=0/0", ffv, busy); end
        checks++; if (stim !== vexp[NV]) begin errors++; $display("FAIL clean_stim_hold got=%h exp=%h", stim, vexp[NV]); end
        repeat (3) @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_done_held got=%b exp=1", done); end
    endtask

    task automatic test_single_fail();
        int at;
        mode = 1;
        do_start();
        wait_done(0, at);
        checks++; if (at != 4000) begin errors++; $display("FAIL single_latency got=%0d exp=4000", at); end
        checks++; if (fail_count !== 32'd1 || vec_count !== 32'd1000) begin errors++; $display("FAIL single_counts got=%0d/%0d exp=1/1000", fail_count, vec_count); end
        checks++; if (ffv !== 1'b1 || ffs !== vexp[5]) begin errors++; $display("FAIL single_stim got=%b/%h exp=1/%h", ffv, ffs, vexp[5]); end
        checks++; if (ffm !== 11'h008) begin errors++; $display("FAIL single_mask got=%h exp=008", ffm); end
        mode = 0;
    endtask

    task automatic test_every_fail();
        int at;
        mode = 2;
        do_start();
        wait_done(0, at);
        checks++; if (at != 4000) begin errors++; $display("FAIL every_latency got=%0d exp=4000", at); end
        checks++; if (fail_count !== 32'd1000) begin errors++; $display("FAIL every_count got=%0d exp=1000", fail_count); end
        checks++; if (ffm !== 11'h401) begin errors++; $display("FAIL every_mask got=%h exp=401", ffm); end
        checks++; if (ffs !== vexp[1]) begin errors++; $display("FAIL every_stim got=%h exp=%h", ffs, vexp[1]); end
        mode = 0;
    endtask

    task automatic test_x_on_spec();
        int at;
        mode = 3;
        do_start();
        checks++; if (fail_count !== 32'd0 || ffv !== 1'b0) begin errors++; $display("FAIL x_cleared got=%0d/%b exp=0/0", fail_count, ffv); end
        wait_done(0, at);
        checks++; if (fail_count !== 32'd1) begin errors++; $display("FAIL x_count got=%0d exp=1", fail_count); end
        checks++; if (ffm !== 11'h080) begin errors++; $display("FAIL x_mask got=%h exp=080", ffm); end
        checks++; if (ffs !== vexp[3]) begin errors++; $display("FAIL x_stim got=%h exp=%h", ffs, vexp[3]); end
        mode = 0;
    endtask

    task automatic test_start_while_busy();
        int at;
        do_start();
        repeat (40) @(posedge clk); #1;
        checks++; if (vec_count !== 32'd10) begin errors++; $display("FAIL busy_pre got=%0d exp=10", vec_count); end
        do_start();
        checks++; if (vec_count !== 32'd10 || busy !== 1'b1) begin errors++; $display("FAIL busy_ignored got=%0d/%b exp=10/1", vec_count, busy); end
        wait_done(41, at);
        checks++; if (at != 4000 || vec_count !== 32'd1000) begin errors++; $display("FAIL busy_finish got=%0d/%0d exp=4000/1000", at, vec_count); end
    endtask

    task automatic test_reset_mid_run();
        bit hit;
        mode = 2;
        do_start();
        hit = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (vec_count == 32'd500) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach500 got=%0d exp=500", vec_count); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mode = 0;
        checks++; if ({stim, busy, done} !== '0) begin errors++; $display("FAIL mid_rst_ctrl got=%h/%b/%b exp=0/0/0", stim, busy, done); end
        checks++; if (vec_count !== 32'd0 || fail_count !== 32'd0) begin errors++; $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", vec_count, fail_count); end
        checks++; if ({ffv, ffs, ffm} !== '0) begin errors++; $display("FAIL mid_rst_ff got=%b/%h/%h exp=0", ffv, ffs, ffm); end
        do_start();
        @(posedge clk); #1;
        for (int j = 1; j <= 3; j++) begin
            checks++; if (stim !== vexp[j]) begin errors++; $display("FAIL replay_stim%0d got=%h exp=%h", j, stim, vexp[j]); end
            if (j < 3) begin repeat (4) @(posedge clk); #1; end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_vecs();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL zero_idle got=%b exp=0", done0); end
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL zero_done got=%b/%b exp=1/0", done0, busy0); end
        checks++; if (vec0 !== 32'd0 || fail0 !== 32'd0 || ffv0 !== 1'b0) begin errors++; $display("FAIL zero_counts got=%0d/%0d/%b exp=0/0/0", vec0, fail0, ffv0); end
    endtask

    initial begin
        build_ref();
        test_reset();
        test_zero_vecs();
        test_clean_run();
        test_single_fail();
        test_every_fail();
        test_x_on_spec();
        test_start_while_busy();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
